// File: rtl/debounce_scan_ctrl.sv
// Shared-prescaler, time-multiplexed debouncer: one evaluator scans N channels per tick.
// Optional DEBOUNCE_SYNC_EN adds a 2-flop synchronizer per raw bit ahead of evaluation.
module debounce_scan_ctrl #(
  parameter int N          = 4,
  parameter int TICK_DIV   = 500000,
  parameter int STABLE_CNT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] raw,
  output logic [N-1:0] db_level,
  output logic [N-1:0] db_rise,
  output logic [N-1:0] db_fall,
  output logic         busy,
  output logic         dbg_state
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LP_TICK_LAST   = CW'(TICK_DIV - 1);
  localparam logic [IW-1:0] LP_IDX_LAST    = IW'(N - 1);
  localparam logic [2:0]    LP_STABLE_LAST = 3'(STABLE_CNT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_div;
  logic [IW-1:0] r_idx;
  logic [N-1:0]  r_level;
  logic [N-1:0]  r_rise;
  logic [N-1:0]  r_fall;
  logic          r_busy;
  logic [2:0]    r_ch_cnt [N];

  logic [N-1:0]  w_raw;
  logic          w_tick;
  logic          w_raw_bit;
  logic          w_lvl_bit;
  logic [2:0]    w_cnt_cur;
  logic          w_expire;

`ifdef DEBOUNCE_SYNC_EN
  logic [N-1:0] r_sync1;
  logic [N-1:0] r_sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_raw = r_sync2;
`else
  assign w_raw = raw;
`endif

  // Prescaler holds its count while en is low; it never clears on en.
  assign w_tick = en && (r_div == LP_TICK_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else if (en) begin
      r_div <= r_div + 1'b1;
    end
  end

  assign w_raw_bit = w_raw[r_idx];
  assign w_lvl_bit = r_level[r_idx];
  assign w_cnt_cur = r_ch_cnt[r_idx];
  assign w_expire  = (w_raw_bit != w_lvl_bit) && (w_cnt_cur == LP_STABLE_LAST);

  // Scan FSM and evaluator. Pulses default low every cycle so they last one clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_level <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      for (int i = 0; i < N; i++) begin
        r_ch_cnt[i] <= '0;
      end
    end else begin
      r_rise <= '0;
      r_fall <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            r_state <= S_SCAN;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_SCAN: begin
          if (w_raw_bit == w_lvl_bit) begin
            r_ch_cnt[r_idx] <= '0;
          end else if (w_expire) begin
            r_ch_cnt[r_idx] <= '0;
            r_level[r_idx]  <= w_raw_bit;
            r_rise[r_idx]   <= w_raw_bit;
            r_fall[r_idx]   <= ~w_raw_bit;
          end else begin
            r_ch_cnt[r_idx] <= w_cnt_cur + 3'd1;
          end
          // A tick landing here is ignored; the scan always runs to the last channel.
          if (r_idx == LP_IDX_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign db_level  = r_level;
  assign db_rise   = r_rise;
  assign db_fall   = r_fall;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Bench for debounce_scan_ctrl: directed test-plan phase then randomized stimulus,
// checked cycle by cycle against a tick/evaluation-schedule reference model.
module tb_debounce_scan_ctrl;

  localparam int N          = 4;
  localparam int TICK_DIV   = 10;
  localparam int STABLE_CNT = 4;
  localparam int W          = 3 * N + 1;

  logic         clk;
  logic         reset;
  logic         en;
  logic [N-1:0] raw;
  logic [N-1:0] db_level;
  logic [N-1:0] db_rise;
  logic [N-1:0] db_fall;
  logic         busy;
  logic         dbg_state;

  int checks;
  int failures;

  logic [W-1:0] exp_q[$];

  // Reference model state: evaluation schedule as (cycle, channel) queues.
  int           m_cyc;
  int           m_div;
  int           m_streak [N];
  logic [N-1:0] m_level;
  int           eval_cyc[$];
  int           eval_ch[$];

  debounce_scan_ctrl #(
    .N(N),
    .TICK_DIV(TICK_DIV),
    .STABLE_CNT(STABLE_CNT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .raw(raw),
    .db_level(db_level),
    .db_rise(db_rise),
    .db_fall(db_fall),
    .busy(busy),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step(input logic r, input logic e, input logic [N-1:0] rw);
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic         busy_n;
    bit           evaluated;
    bit           tick;
    int           c;
    rise      = '0;
    fall      = '0;
    evaluated = 0;
    if (r) begin
      m_level = '0;
      m_div   = 0;
      eval_cyc.delete();
      eval_ch.delete();
      for (int i = 0; i < N; i++) m_streak[i] = 0;
      exp_q.push_back('0);
    end else begin
      if (eval_cyc.size() > 0 && eval_cyc[0] == m_cyc) begin
        c = eval_ch[0];
        void'(eval_cyc.pop_front());
        void'(eval_ch.pop_front());
        evaluated = 1;
        if (rw[c] != m_level[c]) begin
          m_streak[c] = m_streak[c] + 1;
          if (m_streak[c] == STABLE_CNT) begin
            m_streak[c] = 0;
            m_level[c]  = rw[c];
            if (rw[c]) rise[c] = 1'b1;
            else       fall[c] = 1'b1;
          end
        end else begin
          m_streak[c] = 0;
        end
      end
      tick = e && (m_div == TICK_DIV - 1);
      if (e) m_div = (m_div + 1) % TICK_DIV;
      if (tick && !evaluated && eval_cyc.size() == 0) begin
        for (int k = 0; k < N; k++) begin
          eval_cyc.push_back(m_cyc + 1 + k);
          eval_ch.push_back(k);
        end
      end
      busy_n = (eval_cyc.size() > 0) && (eval_cyc[0] == m_cyc + 1);
      exp_q.push_back({busy_n, fall, rise, m_level});
    end
    m_cyc = m_cyc + 1;
  endtask

  // Driver: inputs change at negedge; the model predicts outputs after the next posedge.
  task automatic drive_cycle(input logic r, input logic e, input logic [N-1:0] rw);
    reset = r;
    en    = e;
    raw   = rw;
    model_step(r, e, rw);
    @(negedge clk);
  endtask

  task automatic check_field(input string name, input logic [N-1:0] got,
                             input logic [N-1:0] exp, input int cyc);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s at t=%0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  // Scoreboard monitor
  always @(posedge clk) begin
    logic [W-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_field("db_level", db_level, e[N-1:0], 0);
      check_field("db_rise",  db_rise,  e[2*N-1:N], 0);
      check_field("db_fall",  db_fall,  e[3*N-1:2*N], 0);
      check_field("busy",     {{(N-1){1'b0}}, busy}, {{(N-1){1'b0}}, e[3*N]}, 0);
    end
  end

  initial begin
    logic [N-1:0] target;
    logic [N-1:0] rw;
    int           en_low_left;
    int           rst_left;
    checks   = 0;
    failures = 0;
    m_cyc    = 0;
    m_div    = 0;
    m_level  = '0;
    for (int i = 0; i < N; i++) m_streak[i] = 0;

    repeat (3) drive_cycle(1'b1, 1'b0, '0);

    // All channels rise together, then fall together.
    drive_cycle(1'b0, 1'b1, '0);
    for (int t = 1; t < 50; t++)  drive_cycle(1'b0, 1'b1, 4'b1111);
    for (int t = 50; t < 100; t++) drive_cycle(1'b0, 1'b1, 4'b0000);

    // Bounce on ch1 plus frozen prescaler window with ch2 high.
    repeat (2) drive_cycle(1'b1, 1'b0, '0);
    drive_cycle(1'b0, 1'b1, '0);
    for (int t = 1; t < 60; t++) begin
      rw    = '0;
      rw[1] = (t <= 25);
      rw[2] = 1'b1;
      drive_cycle(1'b0, !(t >= 5 && t <= 14), rw);
    end

    // Reset mid-scan while a rise is pending.
    repeat (2) drive_cycle(1'b1, 1'b0, '0);
    drive_cycle(1'b0, 1'b1, '0);
    for (int t = 1; t < 41; t++) drive_cycle(1'b0, 1'b1, 4'b1111);
    drive_cycle(1'b1, 1'b1, 4'b1111);
    for (int t = 0; t < 30; t++) drive_cycle(1'b0, 1'b1, 4'b1111);

    // Randomized phase: slowly moving targets with occasional glitches, en gaps, resets.
    target      = '0;
    en_low_left = 0;
    rst_left    = 0;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 59) == 0) target[i] = ~target[i];
      end
      rw = target;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 15) == 0) rw[i] = ~rw[i];
      end
      if (en_low_left == 0 && $urandom_range(0, 99) == 0) en_low_left = $urandom_range(1, 20);
      if (rst_left == 0 && $urandom_range(0, 399) == 0)   rst_left = $urandom_range(1, 2);
      drive_cycle(rst_left > 0, en_low_left == 0, rw);
      if (en_low_left > 0) en_low_left = en_low_left - 1;
      if (rst_left > 0)    rst_left = rst_left - 1;
    end

    checks = checks + 1;
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debounce_scan_ctrl.md
Name: debounce_scan_ctrl

Overview:
- Scheduler that shares one millisecond tick prescaler and one time-multiplexed debounce evaluator across N raw button/switch inputs.
- On each tick it scans the channels round-robin, one channel per clock. It keeps a per-channel stability counter and debounced level.
- Emits debounced levels plus one-cycle rise/fall pulses to downstream control logic.
- Replaces N independent per-input debounce FSMs with their own timers.

Parameters:
- N, 4, number of input channels (1..16).
- TICK_DIV, 500000, clocks per debounce tick; must satisfy TICK_DIV > N+1.
- STABLE_CNT, 4, consecutive disagreeing ticks required before a level change (2..7).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous reset, active-high.
- en  input  1  scan enable; low freezes the prescaler.
- raw  input  N  raw inputs, bit i = channel i.
- db_level  output  N  debounced level per channel.
- db_rise  output  N  one-cycle pulse when db_level[i] goes 0->1.
- db_fall  output  N  one-cycle pulse when db_level[i] goes 1->0.
- busy  output  1  high while the FSM is in SCAN.

Behaviour:
- Reset (synchronous, active-high) clears:
  - db_level, db_rise, db_fall, busy
  - prescaler, scan index, all per-channel counters (3 bits each)
  - FSM forced to IDLE.
  - Reset asserted mid-scan aborts the scan immediately. No pulses are generated in the cycle after reset.
- Prescaler: width $clog2(TICK_DIV).
  - Counts 0..TICK_DIV-1 while en=1.
  - tick is combinational, = (cnt==TICK_DIV-1) && en.
  - cnt wraps to 0 on tick.
  - en=0 holds cnt at its value (no clear).
  - First tick occurs TICK_DIV-1 cycles after reset deassertion with en=1.
- FSM states IDLE, SCAN:
  - IDLE: busy=0. On tick -> SCAN with idx=0.
  - SCAN: busy=1. Evaluate channel idx this cycle. If idx==N-1 -> IDLE, else idx+1.
  - A scan in progress always completes, even if en drops mid-scan.
  - A tick cannot land during SCAN because of the TICK_DIV constraint. If one does, it is ignored.
- Evaluation of channel i (registered, visible next cycle):
  - raw[i]==db_level[i]: counter[i] <= 0.
  - raw[i]!=db_level[i] and counter[i]==STABLE_CNT-1: db_level[i] toggles, counter[i] <= 0, and the matching db_rise[i] or db_fall[i] is 1 for exactly one cycle.
  - Otherwise: counter[i] increments.
- Non-evaluated channels hold state. db_rise/db_fall are 0 in every cycle except the one following an evaluation that toggled that channel.
- Latency, tick to output change: channel i updates at cycle tick+1+i+1. Simultaneous changes on several channels therefore produce pulses staggered by one cycle in index order.
- raw is sampled only in the cycle its channel is evaluated. Glitches between evaluations are invisible.

Optional Feature:
- Macro: DEBOUNCE_SYNC_EN.
- Defined: raw passes through a 2-flop synchronizer per bit (reset to 0) before evaluation. This adds 2 cycles of sampling delay and makes asynchronous pin inputs legal.
- Undefined: raw is used directly and must be synchronous to clk.
- Test-plan cycle numbers assume the macro is undefined, with raw stable at least 2 cycles before each evaluation.

Test Plan:
- N=4, TICK_DIV=10, STABLE_CNT=4, en=1. Reset released at cycle 0, raw[0]=1 from cycle 1.
  -> ticks at 9, 19, 29, 39; ch0 evaluated at 10, 20, 30, 40.
  -> db_level[0]=1 and db_rise[0]=1 at cycle 41 only. busy high cycles 10-13, 20-23, etc.
- Bounce: raw[1]=1 from cycle 1 to 25, then 0.
  -> ch1 counter reaches 2 then clears. db_level[1] stays 0, no pulses.
- Simultaneous: raw=4'b1111 from cycle 1.
  -> db_rise[0..3] pulse at cycles 41, 42, 43, 44 respectively. db_level=4'b1111 from cycle 44.
- Falling edge: after all high, raw=0 at cycle 50.
  -> evaluations at 60, 70, 80, 90. db_fall[0]=1 at cycle 91, db_fall[3]=1 at 94.
- Reset mid-scan: assert reset at cycle 41 while db_rise pending.
  -> cycle 42: db_level=0, pulses=0, busy=0. Next tick at cycle 42+9 after deassertion.
- en=0 for cycles 5-14 with raw[2]=1 from cycle 1.
  -> prescaler frozen at 5; ticks shift to 19, 29, 39, 49. db_rise[2] at cycle 53.
